// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-master APB request arbiter.
package apb_arb_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    localparam logic [1:0] PSEL_RM  = 2'b01;
    localparam logic [1:0] PSEL_ICN = 2'b10;
    localparam logic [1:0] PSEL_BAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // One-hot grant; on a tie the master that was not granted last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
        logic [1:0] g;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = last_grant ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB signal bundle; master modport drives requests, slave modport answers them.
interface apb_req_arbiter_if;
    import apb_arb_pkg::*;

    logic [1:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [1:0]        pstrb;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, pstrb, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, pstrb, paddr, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_timeout_ctr.sv
// Saturating ACCESS-phase cycle counter; expired flags the cycle that completes TIMEOUT cycles.
module apb_timeout_ctr #(
    parameter int TIMEOUT = 255,
    localparam int W = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the cycles already spent, so the current one is number cnt+1.
    assign expired = enable && (cnt >= LIMIT - 1'b1);

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter for two APB masters onto one downstream bus, with decode-error and timeout abort.
//   state  | meaning
//   IDLE   | no owner; arbitrate and capture the winner's transfer
//   SETUP  | downstream psel up, penable low
//   ACCESS | penable high; wait for pready or timeout
//   RESP   | owner's pready pulse (decode error spends one extra cycle here first)
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    apb_req_arbiter_if.slave  m0,
    apb_req_arbiter_if.slave  m1,
    apb_req_arbiter_if.master ds,
    output logic [1:0]        grant,
    output logic              timeout_o
);

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic              dec_err;
    logic [1:0]        req;
    logic [1:0]        pick;
    logic [1:0]        sel_psel;
    logic [1:0]        sel_pstrb;
    logic              sel_pwrite;
    logic [ADDR_W-1:0] sel_paddr;
    logic [DATA_W-1:0] sel_pwdata;
    logic              expired;
    logic              fire;
    logic              fire_err;
    logic [DATA_W-1:0] fire_data;

    logic [1:0]        psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [1:0]        pstrb_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [1:0]        rdy_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    assign req        = {|m1.psel, |m0.psel};
    assign pick       = rr_pick(req, last_grant);
    assign sel_psel   = pick[1] ? m1.psel   : m0.psel;
    assign sel_pstrb  = pick[1] ? m1.pstrb  : m0.pstrb;
    assign sel_pwrite = pick[1] ? m1.pwrite : m0.pwrite;
    assign sel_paddr  = pick[1] ? m1.paddr  : m0.paddr;
    assign sel_pwdata = pick[1] ? m1.pwdata : m0.pwdata;

    apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == IDLE),
        .enable  (state == ACCESS),
        .expired (expired)
    );

    // Response to be registered for the owner this cycle.
    always_comb begin
        fire      = 1'b0;
        fire_err  = 1'b0;
        fire_data = '0;
        if (state == ACCESS) begin
            fire      = ds.pready || expired;
            fire_err  = ds.pready ? ds.pslverr : 1'b1;
            fire_data = ds.pready ? ds.prdata : '0;
        end else if (state == RESP) begin
            fire     = dec_err;
            fire_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            dec_err    <= 1'b0;
            grant      <= 2'b00;
            timeout_o  <= 1'b0;
            psel_q     <= 2'b00;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            pstrb_q    <= 2'b00;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            rdy_q      <= 2'b00;
            err_q      <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            rdy_q     <= 2'b00;
            err_q     <= 2'b00;
            timeout_o <= 1'b0;
            if (fire) begin
                rdy_q[owner] <= 1'b1;
                err_q[owner] <= fire_err;
                if (owner) rdata1_q <= fire_data;
                else       rdata0_q <= fire_data;
            end

            case (state)
                IDLE: begin
                    if (|pick) begin
                        grant      <= pick;
                        last_grant <= pick[1];
                        owner      <= pick[1];
                        pwrite_q   <= sel_pwrite;
                        pstrb_q    <= sel_pstrb;
                        paddr_q    <= sel_paddr;
                        pwdata_q   <= sel_pwdata;
                        if (sel_psel == PSEL_BAD) begin
                            dec_err <= 1'b1;
                            state   <= RESP;
                        end else begin
                            psel_q    <= sel_psel;
                            penable_q <= 1'b0;
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (ds.pready || expired) begin
                        psel_q    <= 2'b00;
                        penable_q <= 1'b0;
                        grant     <= 2'b00;
                        timeout_o <= !ds.pready;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (dec_err) begin
                        dec_err <= 1'b0;
                        grant   <= 2'b00;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ds.psel    = psel_q;
    assign ds.penable = penable_q;
    assign ds.pwrite  = pwrite_q;
    assign ds.pstrb   = pstrb_q;
    assign ds.paddr   = paddr_q;
    assign ds.pwdata  = pwdata_q;

    assign m0.pready  = rdy_q[0];
    assign m0.pslverr = err_q[0];
    assign m0.prdata  = rdata0_q;
    assign m1.pready  = rdy_q[1];
    assign m1.pslverr = err_q[1];
    assign m1.prdata  = rdata1_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transaction-timeline model checked every cycle plus directed literal checks.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] grant;
    logic       timeout_o;

    always #5 clk = ~clk;

    apb_req_arbiter_if m0_if ();
    apb_req_arbiter_if m1_if ();
    apb_req_arbiter_if ds_if ();

    apb_req_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0        (m0_if.slave),
        .m1        (m1_if.slave),
        .ds        (ds_if.master),
        .grant     (grant),
        .timeout_o (timeout_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream slave: pready after slv_ws ACCESS wait cycles, never if slv_never.
    int slv_ws    = 0;
    bit slv_never = 1'b0;
    int acc       = 0;
    always @(negedge clk) begin
        if (ds_if.psel != 2'b00 && ds_if.penable) begin
            ds_if.pready = !slv_never && (acc >= slv_ws);
            acc++;
        end else begin
            ds_if.pready = 1'b0;
            acc = 0;
        end
    end

    // Model: timeline of one transfer measured in edges since the grant edge.
    logic [1:0]  e_psel, e_pstrb, e_grant, e_rdy, e_err;
    logic        e_penable, e_pwrite, e_to;
    logic [19:0] e_paddr;
    logic [15:0] e_pwdata;
    logic [15:0] e_rd [2];
    logic        m_busy, m_cool, m_dec, m_last, m_own;
    int          m_t;

    wire mdl_r0  = |m0_if.psel;
    wire mdl_r1  = |m1_if.psel;
    wire mdl_own = (mdl_r0 && mdl_r1) ? ~m_last : mdl_r1;
    wire [1:0] mdl_psel = mdl_own ? m1_if.psel : m0_if.psel;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_psel <= 0; e_pstrb <= 0; e_penable <= 0; e_pwrite <= 0;
            e_paddr <= 0; e_pwdata <= 0; e_grant <= 0; e_to <= 0;
            e_rdy <= 0; e_err <= 0; e_rd[0] <= 0; e_rd[1] <= 0;
            m_busy <= 0; m_cool <= 0; m_dec <= 0; m_last <= 1; m_own <= 0; m_t <= 0;
        end else begin
            e_rdy <= 0; e_err <= 0; e_to <= 0;
            if (m_cool) begin
                m_cool <= 0;
            end else if (!m_busy) begin
                if (mdl_r0 || mdl_r1) begin
                    m_busy   <= 1; m_t <= 0;
                    m_own    <= mdl_own; m_last <= mdl_own;
                    e_grant  <= mdl_own ? 2'b10 : 2'b01;
                    e_pwrite <= mdl_own ? m1_if.pwrite : m0_if.pwrite;
                    e_pstrb  <= mdl_own ? m1_if.pstrb  : m0_if.pstrb;
                    e_paddr  <= mdl_own ? m1_if.paddr  : m0_if.paddr;
                    e_pwdata <= mdl_own ? m1_if.pwdata : m0_if.pwdata;
                    m_dec    <= (mdl_psel == 2'b11);
                    if (mdl_psel != 2'b11) begin
                        e_psel    <= mdl_psel;
                        e_penable <= 0;
                    end
                end
            end else begin
                m_t <= m_t + 1;
                if (!m_dec && m_t == 0) begin
                    e_penable <= 1;
                end else if (m_dec || ds_if.pready || m_t == TO) begin
                    e_psel <= 0; e_penable <= 0; e_grant <= 0;
                    e_rdy[m_own] <= 1;
                    e_err[m_own] <= (m_dec || !ds_if.pready) ? 1'b1 : ds_if.pslverr;
                    e_rd[m_own]  <= (!m_dec && ds_if.pready) ? ds_if.prdata : 16'h0000;
                    e_to   <= !m_dec && !ds_if.pready;
                    m_busy <= 0; m_cool <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("psel",       32'(ds_if.psel),    32'(e_psel));
            chk("penable",    32'(ds_if.penable), 32'(e_penable));
            chk("pwrite",     32'(ds_if.pwrite),  32'(e_pwrite));
            chk("pstrb",      32'(ds_if.pstrb),   32'(e_pstrb));
            chk("paddr",      32'(ds_if.paddr),   32'(e_paddr));
            chk("pwdata",     32'(ds_if.pwdata),  32'(e_pwdata));
            chk("grant",      32'(grant),         32'(e_grant));
            chk("timeout_o",  32'(timeout_o),     32'(e_to));
            chk("m0_pready",  32'(m0_if.pready),  32'(e_rdy[0]));
            chk("m0_pslverr", 32'(m0_if.pslverr), 32'(e_err[0]));
            chk("m0_prdata",  32'(m0_if.prdata),  32'(e_rd[0]));
            chk("m1_pready",  32'(m1_if.pready),  32'(e_rdy[1]));
            chk("m1_pslverr", 32'(m1_if.pslverr), 32'(e_err[1]));
            chk("m1_prdata",  32'(m1_if.prdata),  32'(e_rd[1]));
        end
    end

    logic [1:0] g_q [$];
    logic [1:0] g_prev = 2'b00;
    always @(negedge clk) begin
        if (grant != 2'b00 && g_prev == 2'b00) g_q.push_back(grant);
        g_prev = grant;
    end

    task automatic drive(input int n, input logic [1:0] ps, input logic wr,
                         input logic [19:0] ad, input logic [15:0] wd);
        if (n == 0) begin
            m0_if.psel = ps; m0_if.penable = |ps; m0_if.pwrite = wr;
            m0_if.pstrb = wr ? 2'b11 : 2'b00; m0_if.paddr = ad; m0_if.pwdata = wd;
        end else begin
            m1_if.psel = ps; m1_if.penable = |ps; m1_if.pwrite = wr;
            m1_if.pstrb = wr ? 2'b11 : 2'b00; m1_if.paddr = ad; m1_if.pwdata = wd;
        end
    endtask

    // Issue at a negedge, hold until the master's pready, then release.
    task automatic mreq(input int n, input logic [1:0] ps, input logic wr,
                        input logic [19:0] ad, input logic [15:0] wd);
        logic seen;
        seen = 1'b0;
        drive(n, ps, wr, ad, wd);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (n == 0) ? m0_if.pready : m1_if.pready;
        end
        chk("mreq_done", 32'(seen), 32'h1);
        drive(n, 2'b00, 1'b0, 20'h0, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(0, 2'b00, 1'b0, 20'h0, 16'h0);
        drive(1, 2'b00, 1'b0, 20'h0, 16'h0);
        slv_ws = 0; slv_never = 1'b0;
        ds_if.prdata = 16'h0000; ds_if.pslverr = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive(0, 2'b00, 1'b0, 20'h0, 16'h0);
        drive(1, 2'b00, 1'b0, 20'h0, 16'h0);
        ds_if.pready = 1'b0; ds_if.prdata = 16'h0000; ds_if.pslverr = 1'b0;
        do_reset();
        chk_en = 1'b1;

        // Reset values.
        chk("rst_psel",  32'(ds_if.psel),   32'h0);
        chk("rst_grant", 32'(grant),        32'h0);
        chk("rst_rd0",   32'(m0_if.prdata), 32'h0);

        // Master 0 write, zero wait states.
        fork
            mreq(0, PSEL_RM, 1'b1, 20'h00010, 16'hBEEF);
            begin
                @(negedge clk);
                chk("t1_c1_psel",    32'(ds_if.psel),    32'h1);
                chk("t1_c1_penable", 32'(ds_if.penable), 32'h0);
                chk("t1_c1_grant",   32'(grant),         32'h1);
                @(negedge clk);
                chk("t1_c2_penable", 32'(ds_if.penable), 32'h1);
                chk("t1_c2_paddr",   32'(ds_if.paddr),   32'h00010);
                chk("t1_c2_pwdata",  32'(ds_if.pwdata),  32'hBEEF);
                chk("t1_c2_pwrite",  32'(ds_if.pwrite),  32'h1);
                chk("t1_c2_grant",   32'(grant),         32'h1);
                @(negedge clk);
                chk("t1_c3_m0rdy",   32'(m0_if.pready),  32'h1);
                chk("t1_c3_grant",   32'(grant),         32'h0);
                @(negedge clk);
                chk("t1_c4_m0rdy",   32'(m0_if.pready),  32'h0);
            end
        join

        // Simultaneous reads: master 0 first, then alternation.
        do_reset();
        ds_if.prdata = 16'hA5A5;
        g_q.delete();
        fork
            begin
                mreq(0, PSEL_RM, 1'b0, 20'h00100, 16'h0);
                mreq(0, PSEL_ICN, 1'b0, 20'h00200, 16'h0);
            end
            mreq(1, PSEL_ICN, 1'b0, 20'h00300, 16'h0);
        join
        repeat (2) @(negedge clk);
        chk("t2_ngrants", 32'(g_q.size()), 32'h3);
        chk("t2_g0", 32'(g_q.size() > 0 ? g_q[0] : 2'b00), 32'h1);
        chk("t2_g1", 32'(g_q.size() > 1 ? g_q[1] : 2'b00), 32'h2);
        chk("t2_g2", 32'(g_q.size() > 2 ? g_q[2] : 2'b00), 32'h1);

        // Master 1 ICN read with 3 wait states (pready on the last pre-timeout cycle).
        do_reset();
        slv_ws = 3; ds_if.prdata = 16'h1234;
        fork
            mreq(1, PSEL_ICN, 1'b0, 20'h0F000, 16'h0);
            begin
                repeat (5) @(negedge clk);
                chk("t3_c5_m1rdy", 32'(m1_if.pready), 32'h0);
                @(negedge clk);
                chk("t3_c6_m1rdy", 32'(m1_if.pready),  32'h1);
                chk("t3_c6_m1rd",  32'(m1_if.prdata),  32'h1234);
                chk("t3_c6_m1err", 32'(m1_if.pslverr), 32'h0);
                chk("t3_c6_to",    32'(timeout_o),     32'h0);
                chk("t3_c6_m0rdy", 32'(m0_if.pready),  32'h0);
                chk("t3_c6_m0rd",  32'(m0_if.prdata),  32'h0);
                chk("t3_c6_m0err", 32'(m0_if.pslverr), 32'h0);
            end
        join

        // Slave error passes through on a normal completion.
        slv_ws = 0; ds_if.pslverr = 1'b1; ds_if.prdata = 16'h7777;
        @(negedge clk);
        fork
            mreq(0, PSEL_ICN, 1'b1, 20'h00044, 16'hCAFE);
            begin
                repeat (3) @(negedge clk);
                chk("t3b_c3_m0err", 32'(m0_if.pslverr), 32'h1);
                chk("t3b_c3_to",    32'(timeout_o),     32'h0);
            end
        join
        ds_if.pslverr = 1'b0;

        // Timeout with pready never asserted.
        do_reset();
        slv_never = 1'b1; ds_if.prdata = 16'hDEAD;
        fork
            mreq(0, PSEL_RM, 1'b0, 20'h00020, 16'h0);
            begin
                repeat (5) @(negedge clk);
                chk("t4_c5_psel", 32'(ds_if.psel), 32'h1);
                chk("t4_c5_to",   32'(timeout_o),  32'h0);
                @(negedge clk);
                chk("t4_c6_to",    32'(timeout_o),     32'h1);
                chk("t4_c6_m0rdy", 32'(m0_if.pready),  32'h1);
                chk("t4_c6_m0err", 32'(m0_if.pslverr), 32'h1);
                chk("t4_c6_m0rd",  32'(m0_if.prdata),  32'h0);
                chk("t4_c6_psel",  32'(ds_if.psel),    32'h0);
            end
        join
        slv_never = 1'b0;

        // Decode error on psel 11.
        @(negedge clk);
        fork
            mreq(0, PSEL_BAD, 1'b1, 20'h00030, 16'h5555);
            begin
                @(negedge clk);
                chk("t5_c1_psel", 32'(ds_if.psel), 32'h0);
                @(negedge clk);
                chk("t5_c2_psel",  32'(ds_if.psel),    32'h0);
                chk("t5_c2_m0rdy", 32'(m0_if.pready),  32'h1);
                chk("t5_c2_m0err", 32'(m0_if.pslverr), 32'h1);
            end
        join

        // Reset during ACCESS, then a fresh tie goes to master 0.
        do_reset();
        slv_ws = 2;
        drive(0, PSEL_RM, 1'b1, 20'h00ABC, 16'h1111);
        repeat (2) @(negedge clk);
        chk("t6_c2_penable", 32'(ds_if.penable), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_psel",    32'(ds_if.psel),    32'h0);
        chk("t6_rst_penable", 32'(ds_if.penable), 32'h0);
        chk("t6_rst_paddr",   32'(ds_if.paddr),   32'h0);
        chk("t6_rst_pwdata",  32'(ds_if.pwdata),  32'h0);
        chk("t6_rst_grant",   32'(grant),         32'h0);
        chk("t6_rst_m0rdy",   32'(m0_if.pready),  32'h0);
        drive(0, 2'b00, 1'b0, 20'h0, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        ds_if.prdata = 16'h3C3C;
        fork
            mreq(0, PSEL_RM, 1'b0, 20'h00111, 16'h0);
            mreq(1, PSEL_RM, 1'b0, 20'h00222, 16'h0);
            begin
                @(negedge clk);
                chk("t6_tie_grant", 32'(grant), 32'h1);
            end
        join
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
